// File: rtl/mp_main_mem_pkg.sv
// Shared types and helpers for the multi-port main-memory model.
package mp_main_mem_pkg;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_req_type_t;

    // Index width that stays at least 1 bit for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mp_main_mem_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr; ptr moves past the winner on advance.
module rr_arbiter
    import mp_main_mem_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_aL,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gr
);

    localparam int PW = idx_w(N);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   cand_x;
    logic [PW-1:0] cand;
    logic          found;

    always_comb begin
        gr     = '0;
        ptr_d  = ptr_q;
        found  = 1'b0;
        cand_x = '0;
        cand   = '0;
        for (int i = 0; i < N; i++) begin
            cand_x = {1'b0, ptr_q} + (PW+1)'(i);
            if (cand_x >= (PW+1)'(N)) begin
                cand_x = cand_x - (PW+1)'(N);
            end
            cand = cand_x[PW-1:0];
            if (!found && req[cand]) begin
                found    = 1'b1;
                gr[cand] = 1'b1;
                ptr_d    = (cand == PW'(N-1)) ? '0 : cand + 1'b1;
            end
        end
        if (!advance) begin
            ptr_d = ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mp_main_mem.sv
// Multi-port main memory: round-robin arbitration into a fixed-latency in-order pipeline.
// Optional per-port statistics counters are enabled by defining MAIN_MEM_STATS_EN.
module mp_main_mem
    import mp_main_mem_pkg::*;
#(
    parameter  int N_PORTS     = 2,
    parameter  int N_BLOCKS    = 4096,
    parameter  int BLOCK_BYTES = 8,
    parameter  int LATENCY     = 4,
    localparam int DW          = BLOCK_BYTES * 8,
    localparam int AW          = idx_w(N_BLOCKS),
    localparam int PW          = idx_w(N_PORTS)
) (
    input  logic                   clk,
    input  logic                   rst_aL,
    input  logic                   init,
    input  logic [DW-1:0]          init_mem_state [N_BLOCKS],
    input  logic [N_PORTS-1:0]     req_valid,
    output logic [N_PORTS-1:0]     req_ready,
    input  logic [N_PORTS-1:0]     req_type,
    input  logic [AW-1:0]          req_block_addr [N_PORTS],
    input  logic [DW-1:0]          req_wr_data [N_PORTS],
    input  logic [BLOCK_BYTES-1:0] req_wr_mask [N_PORTS],
    output logic [N_PORTS-1:0]     resp_valid,
    output logic [DW-1:0]          resp_data [N_PORTS],
    output logic [N_PORTS-1:0]     resp_err,
    output logic [DW-1:0]          mem_out [N_BLOCKS]
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [31:0]            stat_reads [N_PORTS],
    output logic [31:0]            stat_writes [N_PORTS],
    output logic [31:0]            stat_stalls [N_PORTS]
`endif
);

    typedef struct packed {
        logic                   valid;
        logic [PW-1:0]          port;
        mem_req_type_t          typ;
        logic [AW-1:0]          addr;
        logic [DW-1:0]          data;
        logic [BLOCK_BYTES-1:0] mask;
    } mp_mem_req_t;

    // Handshake: a request transfers on a cycle where req_valid[p] && req_ready[p];
    // ready is combinational, at most one port is granted, and init or reset forces no grant.
    logic [N_PORTS-1:0] arb_req, grant;

    assign arb_req   = req_valid & {N_PORTS{rst_aL & ~init}};
    assign req_ready = grant;

    rr_arbiter #(.N(N_PORTS)) u_arb (
        .clk     (clk),
        .rst_aL  (rst_aL),
        .req     (arb_req),
        .advance (~init),
        .gr      (grant)
    );

    mp_mem_req_t new_req;
    mp_mem_req_t pipe_q [LATENCY];
    mp_mem_req_t ex;

    always_comb begin
        new_req = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (grant[p]) begin
                new_req.valid = 1'b1;
                new_req.port  = PW'(p);
                new_req.typ   = mem_req_type_t'(req_type[p]);
                new_req.addr  = req_block_addr[p];
                new_req.data  = req_wr_data[p];
                new_req.mask  = req_wr_mask[p];
            end
        end
    end

    // Never stalls; init drops everything in flight.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else if (init) begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= new_req;
            for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign ex = pipe_q[LATENCY-1];

    logic ex_oor;
    generate
        if ((1 << AW) == N_BLOCKS) begin : g_pow2
            assign ex_oor = 1'b0;
        end else begin : g_npow2
            assign ex_oor = {1'b0, ex.addr} >= (AW+1)'(N_BLOCKS);
        end
    endgenerate

    logic [DW-1:0] mem_q [N_BLOCKS];
    logic [DW-1:0] old_blk, merged;
    logic          ex_wr;

    always_comb begin
        old_blk = ex_oor ? '0 : mem_q[ex.addr];
        merged  = old_blk;
        if (ex.typ == MEM_WRITE && !ex_oor) begin
            for (int b = 0; b < BLOCK_BYTES; b++) begin
                if (ex.mask[b]) merged[b*8 +: 8] = ex.data[b*8 +: 8];
            end
        end
    end

    assign ex_wr = ex.valid && (ex.typ == MEM_WRITE) && !ex_oor && !init;

    // The array is deliberately outside reset so contents survive rst_aL.
    always_ff @(posedge clk) begin
        if (init) begin
            mem_q <= init_mem_state;
        end else if (ex_wr) begin
            mem_q[ex.addr] <= merged;
        end
    end

    assign mem_out = mem_q;

    logic [N_PORTS-1:0] resp_valid_q, resp_valid_d;
    logic [N_PORTS-1:0] resp_err_q, resp_err_d;
    logic [DW-1:0]      resp_data_q [N_PORTS];
    logic [DW-1:0]      resp_data_d [N_PORTS];

    always_comb begin
        resp_valid_d = '0;
        resp_err_d   = '0;
        resp_data_d  = resp_data_q;
        if (ex.valid && !init) begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (ex.port == PW'(p)) begin
                    resp_valid_d[p] = 1'b1;
                    resp_err_d[p]   = ex_oor;
                    resp_data_d[p]  = merged;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            resp_valid_q <= '0;
            resp_err_q   <= '0;
            for (int p = 0; p < N_PORTS; p++) resp_data_q[p] <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = resp_data_q;

`ifdef MAIN_MEM_STATS_EN
    logic [31:0] rd_cnt_q [N_PORTS];
    logic [31:0] wr_cnt_q [N_PORTS];
    logic [31:0] st_cnt_q [N_PORTS];

    // Reads/writes are counted at grant; all counters saturate.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            for (int p = 0; p < N_PORTS; p++) begin
                rd_cnt_q[p] <= '0;
                wr_cnt_q[p] <= '0;
                st_cnt_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (init) begin
                    rd_cnt_q[p] <= '0;
                    wr_cnt_q[p] <= '0;
                    st_cnt_q[p] <= '0;
                end else begin
                    if (grant[p] && !req_type[p] && ~&rd_cnt_q[p]) rd_cnt_q[p] <= rd_cnt_q[p] + 1'b1;
                    if (grant[p] && req_type[p] && ~&wr_cnt_q[p]) wr_cnt_q[p] <= wr_cnt_q[p] + 1'b1;
                    if (req_valid[p] && !grant[p] && ~&st_cnt_q[p]) st_cnt_q[p] <= st_cnt_q[p] + 1'b1;
                end
            end
        end
    end

    assign stat_reads  = rd_cnt_q;
    assign stat_writes = wr_cnt_q;
    assign stat_stalls = st_cnt_q;
`endif

endmodule

// File: tb/tb_mp_main_mem.sv
// Directed bench for mp_main_mem (N_BLOCKS=4000 so the out-of-range path exists).
// Stat counter checks are compiled in when MAIN_MEM_STATS_EN is defined.
module tb_mp_main_mem;

    localparam int NP  = 2;
    localparam int NB  = 4000;
    localparam int BB  = 8;
    localparam int LAT = 4;
    localparam int W   = 98;

    localparam logic [63:0] IMG5    = 64'h1122334455667788;
    localparam logic [63:0] IMG9    = 64'h0123456789ABCDEF;
    localparam logic [63:0] IMG3999 = 64'hCAFEF00D12345678;

    logic          clk;
    logic          rst_aL;
    logic          init;
    logic [63:0]   init_img [NB];
    logic [NP-1:0] req_valid;
    logic [NP-1:0] req_ready;
    logic [NP-1:0] req_type;
    logic [11:0]   req_block_addr [NP];
    logic [63:0]   req_wr_data [NP];
    logic [7:0]    req_wr_mask [NP];
    logic [NP-1:0] resp_valid;
    logic [63:0]   resp_data [NP];
    logic [NP-1:0] resp_err;
    logic [63:0]   mem_out [NB];
`ifdef MAIN_MEM_STATS_EN
    logic [31:0]   stat_reads [NP];
    logic [31:0]   stat_writes [NP];
    logic [31:0]   stat_stalls [NP];
`endif

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc     = 0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] mon_e;

    mp_main_mem #(
        .N_PORTS(NP), .N_BLOCKS(NB), .BLOCK_BYTES(BB), .LATENCY(LAT)
    ) dut (
        .clk            (clk),
        .rst_aL         (rst_aL),
        .init           (init),
        .init_mem_state (init_img),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_type       (req_type),
        .req_block_addr (req_block_addr),
        .req_wr_data    (req_wr_data),
        .req_wr_mask    (req_wr_mask),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_err       (resp_err),
        .mem_out        (mem_out)
`ifdef MAIN_MEM_STATS_EN
        ,
        .stat_reads     (stat_reads),
        .stat_writes    (stat_writes),
        .stat_stalls    (stat_stalls)
`endif
    );

    // Clock and cycle count
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: every response must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (resp_valid[p]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp_valid", 64'(resp_valid[p]), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_cycle", 64'(cyc), 64'(mon_e[97:66]));
                    check("resp_port", 64'(p), 64'(mon_e[65]));
                    check("resp_err", 64'(resp_err[p]), 64'(mon_e[64]));
                    check("resp_data", resp_data[p], mon_e[63:0]);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input int p, input logic typ, input logic [11:0] addr,
                         input logic [63:0] data, input logic [7:0] mask,
                         input logic [63:0] exp_data, input logic exp_err, input bit track);
        logic [NP-1:0] rdy;
        rdy = '0;
        rdy[p] = 1'b1;
        req_valid[p]      = 1'b1;
        req_type[p]       = typ;
        req_block_addr[p] = addr;
        req_wr_data[p]    = data;
        req_wr_mask[p]    = mask;
        #1;
        check("issue_ready", 64'(req_ready), 64'(rdy));
        if (track) exp_q.push_back({32'(cyc + 1 + LAT), 1'(p), exp_err, exp_data});
        tick();
        req_valid[p] = 1'b0;
    endtask

    task automatic push_read(input int p, input logic [63:0] d);
        exp_q.push_back({32'(cyc + 1 + LAT), 1'(p), 1'b0, d});
    endtask

    initial begin
        rst_aL    = 1'b0;
        init      = 1'b0;
        req_valid = '0;
        req_type  = '0;
        for (int p = 0; p < NP; p++) begin
            req_block_addr[p] = '0;
            req_wr_data[p]    = '0;
            req_wr_mask[p]    = '0;
        end
        for (int i = 0; i < NB; i++) init_img[i] = '0;
        init_img[5]    = IMG5;
        init_img[9]    = IMG9;
        init_img[3999] = IMG3999;

        // Reset state
        repeat (2) tick();
        req_valid = 2'b11;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_resp_data0", resp_data[0], 64'd0);
        check("rst_resp_data1", resp_data[1], 64'd0);
        req_valid = '0;
        tick();
        rst_aL = 1'b1;
        tick();

        // Preload
        init = 1'b1;
        tick();
        init = 1'b0;
        #1;
        check("init_mem5", mem_out[5], IMG5);
        check("init_mem9", mem_out[9], IMG9);
        check("init_mem3999", mem_out[3999], IMG3999);

        // Single read latency, then bring ptr back to 0
        issue(0, 1'b0, 12'd5, '0, '0, IMG5, 1'b0, 1'b1);
        issue(1, 1'b0, 12'd9, '0, '0, IMG9, 1'b0, 1'b1);
        repeat (LAT + 2) tick();

        // Contention with ptr=0: 0,1,0,1
        req_type = '0;
        req_block_addr[0] = 12'd5;
        req_block_addr[1] = 12'd9;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("alt_ready", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            if (k % 2 == 0) push_read(0, IMG5);
            else            push_read(1, IMG9);
            tick();
        end
        req_valid = '0;
        repeat (LAT + 2) tick();

        // Partial writes and RAW ordering across ports
        issue(1, 1'b1, 12'd5, 64'hAAAAAAAA_DEADBEEF, 8'h0F, 64'h11223344_DEADBEEF, 1'b0, 1'b1);
        issue(0, 1'b0, 12'd5, '0, '0, 64'h11223344_DEADBEEF, 1'b0, 1'b1);
        issue(0, 1'b1, 12'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, IMG9, 1'b0, 1'b1);
        issue(1, 1'b1, 12'd9, 64'hFFEEDDCC_BBAA9988, 8'h81, 64'hFF234567_89ABCD88, 1'b0, 1'b1);
        issue(0, 1'b0, 12'd9, '0, '0, 64'hFF234567_89ABCD88, 1'b0, 1'b1);

        // Range boundaries
        issue(0, 1'b0, 12'd4001, '0, '0, 64'd0, 1'b1, 1'b1);
        issue(0, 1'b0, 12'd4000, '0, '0, 64'd0, 1'b1, 1'b1);
        issue(0, 1'b1, 12'd4000, 64'h5555, 8'hFF, 64'd0, 1'b1, 1'b1);
        issue(0, 1'b0, 12'd3999, '0, '0, IMG3999, 1'b0, 1'b1);
        repeat (LAT + 2) tick();
        check("wr_mem5", mem_out[5], 64'h11223344_DEADBEEF);
        check("wr_mem9", mem_out[9], 64'hFF234567_89ABCD88);

        // Reset mid-operation drops the in-flight read
        issue(0, 1'b0, 12'd5, '0, '0, '0, 1'b0, 1'b0);
        tick();
        rst_aL = 1'b0;
        req_valid[0] = 1'b1;
        #1;
        check("midrst_ready", 64'(req_ready), 64'd0);
        repeat (2) tick();
        req_valid = '0;
        rst_aL = 1'b1;
        repeat (LAT + 2) tick();
        req_valid = 2'b11;
        #1;
        check("postrst_ready_both", 64'(req_ready), 64'd1);
        req_valid = 2'b10;
        #1;
        check("postrst_ready_p1", 64'(req_ready), 64'd2);
        req_valid = '0;
        check("postrst_mem5_kept", mem_out[5], 64'h11223344_DEADBEEF);
        tick();

        // init flushes in-flight work and beats a concurrent request
        issue(0, 1'b0, 12'd9, '0, '0, '0, 1'b0, 1'b0);
        init = 1'b1;
        req_valid[0] = 1'b1;
        req_type[0] = 1'b0;
        req_block_addr[0] = 12'd5;
        #1;
        check("init_ready", 64'(req_ready), 64'd0);
        tick();
        init = 1'b0;
        req_valid = '0;
        #1;
        check("reinit_mem5", mem_out[5], IMG5);
        check("reinit_mem9", mem_out[9], IMG9);
        repeat (LAT + 2) tick();

        // Contention starting from ptr=1: 1,0,1,0,1,0 (3 stalls per port)
        req_type = '0;
        req_block_addr[0] = 12'd5;
        req_block_addr[1] = 12'd9;
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("alt2_ready", 64'(req_ready), (k % 2 == 0) ? 64'd2 : 64'd1);
            if (k % 2 == 0) push_read(1, IMG9);
            else            push_read(0, IMG5);
            tick();
        end
        req_valid = '0;
        #1;
`ifdef MAIN_MEM_STATS_EN
        check("stat_stalls0", 64'(stat_stalls[0]), 64'd3);
        check("stat_stalls1", 64'(stat_stalls[1]), 64'd3);
        check("stat_reads0", 64'(stat_reads[0]), 64'd3);
        check("stat_reads1", 64'(stat_reads[1]), 64'd3);
        check("stat_writes0", 64'(stat_writes[0]), 64'd0);
`endif
        repeat (LAT + 3) tick();

        check("pending_resp", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
